// File: rtl/z80_irq_pkg.sv
// z80_irq_pkg: shared FSM state type and default constants for the Z80 interrupt controller.
package z80_irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_DONE = 2'd2
    } irq_state_e;

    localparam logic [7:0] VEC_BASE_DEF = 8'h90;
    localparam int         VEC_STEP_DEF = 2;
    localparam int         CEN_DIV_DEF  = 8;
    localparam logic [7:0] VEC_SPURIOUS = 8'hFF;

endpackage

// File: rtl/z80_irq_ctrl_if.sv
// z80_irq_ctrl_if: Z80 core strobe / data bus bundle between the core (master) and the interrupt controller (slave).
interface z80_irq_ctrl_if;
    import z80_irq_pkg::*;

    logic       cpu_m1_n;
    logic       cpu_iorq_n;
    logic       cpu_rd_n;
    logic [7:0] bus_din;
    logic [7:0] cpu_di;
    logic       cpu_int_n;
    logic       cpu_nmi_n;

    modport master (
        output cpu_m1_n, cpu_iorq_n, cpu_rd_n, bus_din,
        input  cpu_di, cpu_int_n, cpu_nmi_n
    );

    modport slave (
        input  cpu_m1_n, cpu_iorq_n, cpu_rd_n, bus_din,
        output cpu_di, cpu_int_n, cpu_nmi_n
    );

endinterface

// File: rtl/irq_edge_sync.sv
// irq_edge_sync: two-flop synchroniser for one active-low interrupt pin plus falling-edge detector.
module irq_edge_sync
    import z80_irq_pkg::*;
(
    input  logic clk_sys,
    input  logic reset_n,
    input  logic irq_n,
    output logic fall
);

    logic       sync_p0;
    logic       sync_p1;
    logic       sync_p2;
    logic [1:0] warm;

    // The detector stays blind until a pin level sampled after reset has reached sync_p2,
    // so a pin held low through reset release is never mistaken for a new edge.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            sync_p2 <= 1'b1;
            warm    <= 2'd0;
        end else begin
            sync_p0 <= irq_n;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
            if (warm != 2'd3)
                warm <= warm + 2'd1;
        end
    end

    assign fall = sync_p2 & ~sync_p1 & (warm == 2'd3);

endmodule

// File: rtl/z80_irq_ctrl.sv
// z80_irq_ctrl: Z80 IM2 interrupt controller with edge-latched channels, vector acknowledge and core clock enable.
// Build option Z80IRQ_NMI_EN routes channel 0 to cpu_nmi_n instead of INT arbitration.
module z80_irq_ctrl
    import z80_irq_pkg::*;
#(
    parameter int         NCH      = 4,
    parameter int         CEN_DIV  = CEN_DIV_DEF,
    parameter logic [7:0] VEC_BASE = VEC_BASE_DEF,
    parameter int         VEC_STEP = VEC_STEP_DEF,
    parameter int         NMI_LEN  = 4
) (
    input  logic           clk_sys,
    input  logic           reset_n,
    input  logic [NCH-1:0] irq_n,
    input  logic [NCH-1:0] irq_mask,
    z80_irq_ctrl_if.slave  cpu,
    output logic           cen,
    output logic [NCH-1:0] pending,
    output logic           ack_valid,
    output logic [2:0]     ack_ch
);

`ifdef Z80IRQ_NMI_EN
    localparam bit NMI_EN = 1'b1;
`else
    localparam bit NMI_EN = 1'b0;
`endif

    localparam logic [1:0]    S_IDLE   = ST_IDLE;
    localparam logic [1:0]    S_ACK    = ST_ACK;
    localparam logic [1:0]    S_DONE   = ST_DONE;
    localparam int            CW       = (CEN_DIV > 2) ? $clog2(CEN_DIV) : 1;
    localparam logic [CW-1:0] CEN_LAST = CW'(CEN_DIV - 1);
    localparam int            NW       = $clog2(NMI_LEN + 1);
    localparam logic [NW-1:0] NMI_LOAD = NW'(NMI_LEN);

    function automatic logic [7:0] vec_for(input logic [2:0] ch);
        int v;
        v = int'(VEC_BASE) + int'(ch) * VEC_STEP;
        return v[7:0];
    endfunction

    // Returns {hit, index} of the lowest set request bit.
    function automatic logic [3:0] pick_lowest(input logic [NCH-1:0] req_v);
        logic [3:0] res;
        res = 4'b0;
        for (int i = NCH - 1; i >= 0; i--)
            if (req_v[i])
                res = {1'b1, 3'(i)};
        return res;
    endfunction

    logic [1:0]     state;
    logic [NCH-1:0] fall;
    logic [NCH-1:0] int_chan;
    logic [NCH-1:0] req;
    logic [NCH-1:0] clr;
    logic [NCH-1:0] pending_d;
    logic [3:0]     sel;
    logic           ack_start;
    logic           ack_hit;
    logic           int_n_q;
    logic [7:0]     di_q;
    logic [CW-1:0]  cen_cnt;
    logic [NW-1:0]  nmi_cnt;
    logic           nmi_trig;

    for (genvar g = 0; g < NCH; g++) begin : g_sync
        irq_edge_sync u_sync (
            .clk_sys (clk_sys),
            .reset_n (reset_n),
            .irq_n   (irq_n[g]),
            .fall    (fall[g])
        );
    end

    always_comb begin
        int_chan = '1;
        if (NMI_EN)
            int_chan[0] = 1'b0;
    end

    // Arbitration: a new edge is OR-ed in after the ack clear, so set wins on collision.
    always_comb begin
        req       = pending & irq_mask & int_chan;
        sel       = pick_lowest(req);
        ack_start = (state == S_IDLE) && !cpu.cpu_iorq_n && !cpu.cpu_m1_n;
        ack_hit   = ack_start && sel[3];
        clr       = '0;
        for (int i = 0; i < NCH; i++)
            clr[i] = ack_hit && (sel[2:0] == 3'(i));
        pending_d = (pending & ~clr) | (fall & int_chan);
        nmi_trig  = NMI_EN && fall[0];
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (ack_start) state <= S_ACK;
                S_ACK:   if (cpu.cpu_iorq_n) state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            pending   <= '0;
            int_n_q   <= 1'b1;
            ack_valid <= 1'b0;
            ack_ch    <= 3'd0;
            di_q      <= 8'h00;
        end else begin
            pending   <= pending_d;
            int_n_q   <= ~|req;
            ack_valid <= ack_hit;
            if (ack_hit)
                ack_ch <= sel[2:0];
            if (ack_start)
                di_q <= sel[3] ? vec_for(sel[2:0]) : VEC_SPURIOUS;
            else if (state != S_ACK && !cpu.cpu_rd_n)
                di_q <= cpu.bus_din;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            cen_cnt <= '0;
        else if (cen_cnt == CEN_LAST)
            cen_cnt <= '0;
        else
            cen_cnt <= cen_cnt + 1'b1;
    end

    // NMI width is counted in cen pulses; a fresh edge reloads the count.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            nmi_cnt <= '0;
        else if (nmi_trig)
            nmi_cnt <= NMI_LOAD;
        else if (cen && nmi_cnt != '0)
            nmi_cnt <= nmi_cnt - 1'b1;
    end

    assign cen           = (cen_cnt == CEN_LAST);
    assign cpu.cpu_int_n = int_n_q;
    assign cpu.cpu_nmi_n = (nmi_cnt == '0);
    assign cpu.cpu_di    = di_q;

endmodule

// File: tb/tb_z80_irq_ctrl.sv
// tb_z80_irq_ctrl: directed and randomized bench for z80_irq_ctrl against an in-bench behavioural model.
module tb_z80_irq_ctrl;

    localparam int NCH     = 4;
    localparam int CEN_DIV = 8;
    localparam int VB      = 'h90;
    localparam int VS      = 2;
    localparam int NMI_LEN = 4;
`ifdef Z80IRQ_NMI_EN
    localparam bit NMI = 1'b1;
`else
    localparam bit NMI = 1'b0;
`endif

    logic           clk_sys = 1'b0;
    logic           reset_n;
    logic [NCH-1:0] irq_n;
    logic [NCH-1:0] irq_mask;
    logic [NCH-1:0] pending;
    logic           cen;
    logic           ack_valid;
    logic [2:0]     ack_ch;

    int n_checks = 0;
    int n_errors = 0;
    int cen_cnt;
    int lowcen;
    int seen;
    int intlow;

    z80_irq_ctrl_if bus ();

    z80_irq_ctrl #(
        .NCH      (NCH),
        .CEN_DIV  (CEN_DIV),
        .VEC_BASE (8'h90),
        .VEC_STEP (VS),
        .NMI_LEN  (NMI_LEN)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .irq_n     (irq_n),
        .irq_mask  (irq_mask),
        .cpu       (bus),
        .cen       (cen),
        .pending   (pending),
        .ack_valid (ack_valid),
        .ack_ch    (ack_ch)
    );

    always #5 clk_sys = ~clk_sys;

    // Model state: edges since release, pin samples (newest first), and spec-level outputs.
    int             m_cyc;
    logic [NCH-1:0] hist[$];
    logic [NCH-1:0] m_pend;
    logic           m_int_n;
    logic           m_valid;
    logic [7:0]     m_di;
    logic [2:0]     m_ch;
    int             m_phase;
    int             m_nmi_left;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [NCH-1:0] intc;
        logic [NCH-1:0] req;
        logic [NCH-1:0] fell;
        logic [NCH-1:0] clr;
        int             sel;
        bit             start;
        bit             cen_prev;
        intc = '1;
        if (NMI) intc[0] = 1'b0;
        if (!reset_n) begin
            m_cyc = 0;
            hist.delete();
            m_pend = '0;
            m_int_n = 1'b1;
            m_valid = 1'b0;
            m_di = 8'h00;
            m_ch = 3'd0;
            m_phase = 0;
            m_nmi_left = 0;
            return;
        end
        m_cyc++;
        fell = '0;
        if (m_cyc >= 4) fell = hist[2] & ~hist[1];
        hist.push_front(irq_n);
        if (hist.size() > 3) void'(hist.pop_back());
        cen_prev = ((m_cyc - 1) % CEN_DIV) == CEN_DIV - 1;
        req = m_pend & irq_mask & intc;
        m_int_n = ~|req;
        start = (m_phase == 0) && !bus.cpu_iorq_n && !bus.cpu_m1_n;
        sel = -1;
        for (int i = 0; i < NCH; i++)
            if (req[i]) begin
                sel = i;
                break;
            end
        clr = '0;
        m_valid = 1'b0;
        if (start) begin
            m_phase = 1;
            if (sel >= 0) begin
                clr[sel] = 1'b1;
                m_ch = 3'(sel);
                m_valid = 1'b1;
                m_di = 8'((VB + sel * VS) % 256);
            end else begin
                m_di = 8'hFF;
            end
        end else begin
            if (m_phase != 1 && !bus.cpu_rd_n) m_di = bus.bus_din;
            if (m_phase == 1) begin
                if (bus.cpu_iorq_n) m_phase = 2;
            end else if (m_phase == 2) begin
                m_phase = 0;
            end
        end
        m_pend = (m_pend & ~clr) | (fell & intc);
        if (NMI && fell[0]) m_nmi_left = NMI_LEN;
        else if (cen_prev && m_nmi_left > 0) m_nmi_left--;
    endtask

    task automatic compare_all();
        bit exp_cen;
        exp_cen = (m_cyc % CEN_DIV) == CEN_DIV - 1;
        chk("pending", 8'(pending), 8'(m_pend));
        chk("cpu_int_n", 8'(bus.cpu_int_n), 8'(m_int_n));
        chk("cpu_nmi_n", 8'(bus.cpu_nmi_n), 8'(m_nmi_left == 0));
        chk("cen", 8'(cen), 8'(exp_cen));
        chk("cpu_di", bus.cpu_di, m_di);
        chk("ack_valid", 8'(ack_valid), 8'(m_valid));
        chk("ack_ch", 8'(ack_ch), 8'(m_ch));
    endtask

    initial begin
        forever begin
            @(posedge clk_sys);
            model_step();
            #1;
            compare_all();
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #3;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic ack_begin();
        bus.cpu_m1_n   = 1'b0;
        bus.cpu_iorq_n = 1'b0;
    endtask

    task automatic ack_end();
        bus.cpu_m1_n   = 1'b1;
        bus.cpu_iorq_n = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_pending"}, 8'(pending), 8'h00);
        chk({tag, "_int_n"}, 8'(bus.cpu_int_n), 8'h01);
        chk({tag, "_nmi_n"}, 8'(bus.cpu_nmi_n), 8'h01);
        chk({tag, "_cen"}, 8'(cen), 8'h00);
        chk({tag, "_di"}, bus.cpu_di, 8'h00);
        chk({tag, "_valid"}, 8'(ack_valid), 8'h00);
        chk({tag, "_ch"}, 8'(ack_ch), 8'h00);
    endtask

    initial begin
        reset_n        = 1'b0;
        irq_n          = '1;
        irq_mask       = '1;
        bus.cpu_m1_n   = 1'b1;
        bus.cpu_iorq_n = 1'b1;
        bus.cpu_rd_n   = 1'b1;
        bus.bus_din    = 8'h00;
        ticks(2);
        check_reset_vals("rst");
        reset_n = 1'b1;

        // cen cadence from reset release
        cen_cnt = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (cen) cen_cnt++;
            if (k == 7) chk("cen_at_7", 8'(cen), 8'h01);
            if (k == 8) chk("cen_at_8", 8'(cen), 8'h00);
        end
        chk("cen_count_16", 8'(cen_cnt), 8'd2);

        // single edge on channel 2, then acknowledge
        irq_n[2] = 1'b0;
        ticks(2);
        chk("s1_pend_early", 8'(pending), 8'h00);
        tick();
        chk("s1_pending", 8'(pending), 8'h04);
        chk("s1_int_n_lag", 8'(bus.cpu_int_n), 8'h01);
        tick();
        chk("s1_int_n", 8'(bus.cpu_int_n), 8'h00);
        irq_n[2] = 1'b1;
        ack_begin();
        tick();
        chk("s1_vec", bus.cpu_di, 8'h94);
        chk("s1_ch", 8'(ack_ch), 8'd2);
        chk("s1_valid", 8'(ack_valid), 8'h01);
        chk("s1_pend_clr", 8'(pending), 8'h00);
        ack_end();
        tick();
        chk("s1_valid_once", 8'(ack_valid), 8'h00);
        chk("s1_int_n_rel", 8'(bus.cpu_int_n), 8'h01);
        tick();

        // channels 1 and 3 together: priority order
        irq_n[1] = 1'b0;
        irq_n[3] = 1'b0;
        ticks(4);
        chk("s2_pending", 8'(pending), 8'h0A);
        ack_begin();
        tick();
        chk("s2_vec1", bus.cpu_di, 8'h92);
        chk("s2_ch1", 8'(ack_ch), 8'd1);
        ack_end();
        ticks(2);
        ack_begin();
        tick();
        chk("s2_vec2", bus.cpu_di, 8'h96);
        chk("s2_ch2", 8'(ack_ch), 8'd3);
        ack_end();
        ticks(2);
        irq_n = '1;

        // masked channel latches but does not interrupt
        irq_mask = '0;
        tick();
        irq_n[1] = 1'b0;
        ticks(5);
        chk("s3_pending", 8'(pending), 8'h02);
        chk("s3_int_n_masked", 8'(bus.cpu_int_n), 8'h01);
        irq_mask = 4'b0010;
        tick();
        chk("s3_int_n_unmasked", 8'(bus.cpu_int_n), 8'h00);
        irq_mask = '1;
        irq_n[1] = 1'b1;
        ack_begin();
        tick();
        chk("s3_vec", bus.cpu_di, 8'h92);
        ack_end();
        ticks(2);

        // spurious ack, then edge colliding with the clear
        ack_begin();
        tick();
        chk("s4_spur_vec", bus.cpu_di, 8'hFF);
        chk("s4_spur_valid", 8'(ack_valid), 8'h00);
        chk("s4_spur_pend", 8'(pending), 8'h00);
        ack_end();
        ticks(2);
        irq_n[3] = 1'b0;
        ticks(3);
        chk("s4_pend3", 8'(pending), 8'h08);
        irq_n[3] = 1'b1;
        ticks(2);
        irq_n[3] = 1'b0;
        ticks(2);
        ack_begin();
        tick();
        chk("s4_ch", 8'(ack_ch), 8'd3);
        chk("s4_valid", 8'(ack_valid), 8'h01);
        chk("s4_set_wins", 8'(pending), 8'h08);
        ack_end();
        ticks(2);
        irq_n[3] = 1'b1;
        ack_begin();
        tick();
        chk("s4_vec_again", bus.cpu_di, 8'h96);
        ack_end();
        ticks(2);

        // reset in the middle of an acknowledge
        irq_n[2] = 1'b0;
        ticks(4);
        ack_begin();
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check_reset_vals("rst2");
        ack_end();
        ticks(2);
        reset_n = 1'b1;
        ticks(8);
        chk("s5_no_edge_after_rst", 8'(pending), 8'h00);
        chk("s5_no_valid", 8'(ack_valid), 8'h00);
        irq_n[2] = 1'b1;
        ticks(2);

`ifdef Z80IRQ_NMI_EN
        irq_n[0] = 1'b0;
        lowcen = 0;
        seen = 0;
        intlow = 0;
        for (int k = 0; k < 400; k++) begin
            tick();
            if (!bus.cpu_int_n) intlow = 1;
            if (!bus.cpu_nmi_n) begin
                seen = 1;
                if (cen) lowcen++;
            end else if (seen != 0) begin
                break;
            end
        end
        chk("nmi_cen_pulses", 8'(lowcen), 8'd4);
        chk("nmi_int_n_quiet", 8'(intlow), 8'd0);
        irq_n[0] = 1'b1;
        ticks(2);
`endif

        for (int c = 0; c < 3000; c++) begin
            tick();
            reset_n = ($urandom_range(0, 599) != 0);
            for (int i = 0; i < NCH; i++)
                if ($urandom_range(0, 9) == 0) irq_n[i] = ~irq_n[i];
            if ($urandom_range(0, 39) == 0) irq_mask = NCH'($urandom);
            bus.cpu_m1_n   = ($urandom_range(0, 2) != 0);
            bus.cpu_iorq_n = ($urandom_range(0, 3) != 0);
            bus.cpu_rd_n   = ($urandom_range(0, 1) != 0);
            bus.bus_din    = 8'($urandom);
        end
        reset_n = 1'b1;
        ticks(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/z80_irq_ctrl.md
Z80_IRQ_CTRL -- requirements
Module: z80_irq_ctrl

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning number of interrupt channels (range 1..8).
REQ-002 SHALL have parameter CEN_DIV, default 8, meaning clk_sys cycles per cen pulse (range 2..256).
REQ-003 SHALL have parameter VEC_BASE, default 8'h90, meaning IM2 vector for channel 0.
REQ-004 SHALL have parameter VEC_STEP, default 2, meaning vector increment per channel.
REQ-005 SHALL have parameter NMI_LEN, default 4, meaning nmi_n low duration in cen pulses.
REQ-006 SHALL have these ports: clk_sys in 1, system clock; reset_n in 1, reset.
REQ-007 SHALL have these ports: irq_n in NCH, active-low interrupt requests, asynchronous; irq_mask in NCH, 1 = channel enabled.
REQ-008 SHALL have these ports: cpu_m1_n, cpu_iorq_n, cpu_rd_n in 1 each, Z80 core strobes; bus_din in 8, system read data.
REQ-009 SHALL have these ports: cpu_di out 8, data to core; cpu_int_n out 1; cpu_nmi_n out 1; cen out 1, core clock enable.
REQ-010 SHALL have these ports: pending out NCH, latched requests; ack_valid out 1, one-cycle ack pulse; ack_ch out 3, acknowledged channel.
REQ-011 SHALL use a single clock, clk_sys; reset_n SHALL be asynchronous and active-low.

Function
REQ-012 SHALL synchronise each irq_n through 2 flops, then detect a falling edge on the synchronised signal, 3 cycles after the pin falls.
REQ-013 SHALL set pending[i] on a falling edge, regardless of mask.
REQ-014 SHALL drive cpu_int_n = ~|(pending & irq_mask), registered, with 1-cycle latency.
REQ-015 SHALL define ack start as the first cycle with cpu_iorq_n=0 and cpu_m1_n=0 while in state IDLE.
REQ-016 SHALL use FSM states IDLE, ACK, DONE.
- IDLE -> ACK: on ack start.
- ACK -> DONE: when cpu_iorq_n=1.
- DONE -> IDLE: next cycle.
REQ-017 SHALL, at ack start, select the lowest-index channel with pending & irq_mask, clear its pending bit, set ack_ch, and pulse ack_valid for 1 cycle.
REQ-018 SHALL, while in ACK, drive cpu_di = VEC_BASE + ack_ch*VEC_STEP, computed mod 256.
REQ-019 SHALL, on spurious ack (nothing enabled pending), drive cpu_di = 8'hFF, pulse no ack_valid, and clear no bit.
REQ-020 SHALL, outside ACK, latch bus_din into cpu_di every cycle cpu_rd_n=0, and hold it otherwise.
REQ-021 SHALL give set priority over clear when a new edge and an ack clear hit the same channel in the same cycle: the bit remains 1.
REQ-022 SHALL leave pending bits untouched on a mask change; the change affects cpu_int_n only.
REQ-023 SHALL count cen modulo CEN_DIV and pulse cen high for 1 cycle when the count = CEN_DIV-1.

Reset
REQ-024 SHALL, while reset_n=0, hold all outputs at these values: pending=0, cpu_int_n=1, cpu_nmi_n=1, cen=0, cpu_di=8'h00, ack_valid=0, ack_ch=0.
REQ-025 SHALL, while reset_n=0, set the FSM to IDLE, clear the cen counter, and set the synchroniser flops to 1.
REQ-026 SHALL abort an in-progress ack on reset with no ack_valid; after release, a still-low irq_n SHALL NOT register an edge.

Configuration
REQ-027 SHALL, with Z80IRQ_NMI_EN defined, route channel 0 to NMI:
- an edge drives cpu_nmi_n=0 for NMI_LEN cen pulses, ignoring irq_mask[0];
- channel 0 is excluded from INT arbitration, and pending[0] reads 0;
- an edge during an active NMI pulse restarts the count.
REQ-028 SHALL, with Z80IRQ_NMI_EN undefined, tie cpu_nmi_n to 1 and treat channel 0 as a normal INT channel.

Structure
REQ-029 SHALL place the FSM state enum, default VEC_BASE/VEC_STEP/CEN_DIV constants and the spurious vector 8'hFF in package z80_irq_pkg.
REQ-030 SHALL implement the per-channel 2-flop synchroniser plus falling-edge detector as sub-module irq_edge_sync, instantiated NCH times.

Verification
REQ-031 SHALL cover these directed scenarios:
- Edge on irq_n[2], mask=4'b1111 -> pending=4'b0100 after 3 cycles, cpu_int_n=0 one cycle later; an ack cycle gives cpu_di=8'h94, ack_ch=2, ack_valid pulse, pending=0, cpu_int_n=1.
- Channels 1 and 3 pending, both enabled -> first ack vector 8'h92, second 8'h96.
- Edge on channel 1 with mask=4'b0000 -> cpu_int_n stays 1, pending=4'b0010; mask set to 4'b0010 -> cpu_int_n=0 next cycle.
- Ack with nothing pending -> cpu_di=8'hFF, no ack_valid pulse; re-edge on channel 3 in the clear cycle -> pending[3] stays 1.
- CEN_DIV=8 -> cen high exactly 1 cycle in 8 from reset release; reset asserted mid-ACK -> all outputs return to REQ-024 values.
- Z80IRQ_NMI_EN, edge on channel 0 -> cpu_nmi_n low for exactly 4 cen pulses, cpu_int_n stays 1.
